// File: rtl/sr_cmd_conditioner.sv
// Conditions two raw asynchronous set/clear requests into single-cycle S/R pulses.
// Each input is synchronised and debounced; clear wins when both rise together.
module sr_cmd_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EVT_W           = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SET_IN,
  input  logic             CLR_IN,
  output logic             S,
  output logic             R,
  output logic             SET_LVL,
  output logic             CLR_LVL,
  output logic             DROP,
  output logic [EVT_W-1:0] EVT_CNT
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_RISE_CHK,
    ST_HIGH,
    ST_FALL_CHK
  } db_state_t;

  // Channel 0 is the set request, channel 1 the clear request.
  logic [1:0] raw_in;
  logic [1:0] lvl_bit;
  logic [1:0] rise_req;

  assign raw_in = {CLR_IN, SET_IN};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   sync;
      db_state_t              state_reg, state_next;
      logic [CNT_W-1:0]       cnt_reg, cnt_next;
      logic                   lvl_reg, lvl_next;
      logic                   req_next;

      always_ff @(posedge CLK) begin
        if (RST) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in[gi]};
        end
      end

      assign sync = sync_reg[SYNC_STAGES-1];

      always_ff @(posedge CLK) begin
        if (RST) begin
          state_reg <= ST_LOW;
          cnt_reg   <= '0;
          lvl_reg   <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          lvl_reg   <= lvl_next;
        end
      end

      // cnt holds the number of consecutive samples already seen at the new level.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        lvl_next   = lvl_reg;
        req_next   = 1'b0;
        case (state_reg)
          ST_LOW: begin
            if (sync) begin
              state_next = ST_RISE_CHK;
              cnt_next   = CNT_W'(1);
            end
          end
          ST_RISE_CHK: begin
            if (!sync) begin
              state_next = ST_LOW;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_next = ST_HIGH;
              cnt_next   = '0;
              lvl_next   = 1'b1;
              req_next   = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          ST_HIGH: begin
            if (!sync) begin
              state_next = ST_FALL_CHK;
              cnt_next   = CNT_W'(1);
            end
          end
          ST_FALL_CHK: begin
            if (sync) begin
              state_next = ST_HIGH;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_next = ST_LOW;
              cnt_next   = '0;
              lvl_next   = 1'b0;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          default: begin
            state_next = ST_LOW;
            cnt_next   = '0;
            lvl_next   = 1'b0;
          end
        endcase
      end

      assign rise_req[gi] = req_next;
      assign lvl_bit[gi]  = lvl_reg;
    end
  endgenerate

  logic             s_reg, r_reg, drop_reg;
  logic [EVT_W-1:0] evt_cnt_reg;

  // Pulses register on the same edge the level rises; clear has priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s_reg       <= 1'b0;
      r_reg       <= 1'b0;
      drop_reg    <= 1'b0;
      evt_cnt_reg <= '0;
    end else begin
      s_reg    <= rise_req[0] & ~rise_req[1];
      r_reg    <= rise_req[1];
      drop_reg <= rise_req[0] & rise_req[1];
      if (rise_req[0] | rise_req[1]) begin
        evt_cnt_reg <= evt_cnt_reg + EVT_W'(1);
      end
    end
  end

  assign S       = s_reg;
  assign R       = r_reg;
  assign DROP    = drop_reg;
  assign SET_LVL = lvl_bit[0];
  assign CLR_LVL = lvl_bit[1];
  assign EVT_CNT = evt_cnt_reg;

endmodule
